// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and RAM-side signal bundle for mem_arbiter.
//   slave  : arbiter view (requests, RAM read data in; grants, read return,
//            RAM controls, range errors out)
//   master : requesters/RAM view (the mirror image)
// Address and data vectors keep the codebase ordering (bit 0 = MSB).
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [1:0]        rd_req;
  logic [0:ADDR_W-1] rd_addr0;
  logic [0:ADDR_W-1] rd_addr1;
  logic [1:0]        rd_gnt;
  logic [1:0]        rd_valid;
  logic [0:DATA_W-1] rd_data;
  logic [1:0]        wr_req;
  logic [0:ADDR_W-1] wr_addr0;
  logic [0:ADDR_W-1] wr_addr1;
  logic [0:DATA_W-1] wr_data0;
  logic [0:DATA_W-1] wr_data1;
  logic [1:0]        wr_gnt;
  logic              mem_read_enable;
  logic [0:ADDR_W-1] mem_read_address;
  logic [0:DATA_W-1] mem_read_data;
  logic              mem_write_enable;
  logic [0:ADDR_W-1] mem_write_address;
  logic [0:DATA_W-1] mem_write_data;
  logic [1:0]        range_err;

  modport slave (
    input  rd_req, rd_addr0, rd_addr1, wr_req, wr_addr0, wr_addr1,
           wr_data0, wr_data1, mem_read_data,
    output rd_gnt, rd_valid, rd_data, wr_gnt, mem_read_enable,
           mem_read_address, mem_write_enable, mem_write_address,
           mem_write_data, range_err
  );

  modport master (
    output rd_req, rd_addr0, rd_addr1, wr_req, wr_addr0, wr_addr1,
           wr_data0, wr_data1, mem_read_data,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, mem_read_enable,
           mem_read_address, mem_write_enable, mem_write_address,
           mem_write_data, range_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync-read/sync-write dual-port RAM between
// requester 0 (j1 CPU) and requester 1 (DMA/loader). Read and write ports
// are round-robin arbitrated independently; read data returns one cycle
// after the grant with a one-hot rd_valid owner strobe.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - mem_arbiter_if.slave: requests/grants, read return, RAM side,
//           range_err pulses for accesses at addresses >= MEM_DEPTH
// Optional feature macro: MEM_ARB_WRITE_FORWARD_EN - a same-cycle read and
// write to the same in-range address returns the new write data.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  logic              rd_last_q, rd_last_d;
  logic              wr_last_q, wr_last_d;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic              rd_oor_q, rd_oor_d;
  logic [1:0]        range_err_q, range_err_d;

  logic [1:0]        rd_gnt, wr_gnt;
  logic [0:ADDR_W-1] rd_addr, wr_addr;
  logic [0:DATA_W-1] wr_data;
  logic              rd_inr, wr_inr;

  // Lone requester wins; on contention the one not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = '0;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

  always_comb begin
    rd_gnt = '0;
    wr_gnt = '0;
    if (!reset) begin
      rd_gnt = rr_pick(bus.rd_req, rd_last_q);
      wr_gnt = rr_pick(bus.wr_req, wr_last_q);
    end
    rd_addr = rd_gnt[1] ? bus.rd_addr1 : bus.rd_addr0;
    wr_addr = wr_gnt[1] ? bus.wr_addr1 : bus.wr_addr0;
    wr_data = wr_gnt[1] ? bus.wr_data1 : bus.wr_data0;
    rd_inr  = {1'b0, rd_addr} < DEPTH_L;
    wr_inr  = {1'b0, wr_addr} < DEPTH_L;

    bus.rd_gnt            = rd_gnt;
    bus.wr_gnt            = wr_gnt;
    bus.mem_read_enable   = (|rd_gnt) && rd_inr;
    bus.mem_read_address  = rd_addr;
    bus.mem_write_enable  = (|wr_gnt) && wr_inr;
    bus.mem_write_address = wr_addr;
    bus.mem_write_data    = wr_data;

    rd_last_d   = (|rd_gnt) ? rd_gnt[1] : rd_last_q;
    wr_last_d   = (|wr_gnt) ? wr_gnt[1] : wr_last_q;
    rd_valid_d  = rd_gnt;
    rd_oor_d    = !rd_inr;
    range_err_d = (rd_gnt & {2{!rd_inr}}) | (wr_gnt & {2{!wr_inr}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_last_q   <= 1'b1;
      wr_last_q   <= 1'b1;
      rd_valid_q  <= '0;
      rd_oor_q    <= 1'b0;
      range_err_q <= '0;
    end else begin
      rd_last_q   <= rd_last_d;
      wr_last_q   <= wr_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_oor_q    <= rd_oor_d;
      range_err_q <= range_err_d;
    end
  end

`ifdef MEM_ARB_WRITE_FORWARD_EN
  logic              fwd_hit_q, fwd_hit_d;
  logic [0:DATA_W-1] fwd_data_q;

  always_comb begin
    fwd_hit_d = bus.mem_read_enable && bus.mem_write_enable && (rd_addr == wr_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= wr_data;
    end
  end
`endif

  // Return data is a pass-through of the RAM output, zeroed when no read
  // is being returned or when the returned read was out of range.
  always_comb begin
    bus.rd_data = '0;
    if ((|rd_valid_q) && !rd_oor_q) begin
`ifdef MEM_ARB_WRITE_FORWARD_EN
      bus.rd_data = fwd_hit_q ? fwd_data_q : bus.mem_read_data;
`else
      bus.rd_data = bus.mem_read_data;
`endif
    end
    bus.rd_valid  = rd_valid_q;
    bus.range_err = range_err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: sync read, sync write, read-before-write.
  logic [15:0] ram [0:4095];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_read_enable)  ram_q <= ram[bus.mem_read_address[4:15]];
    if (bus.mem_write_enable) ram[bus.mem_write_address[4:15]] <= bus.mem_write_data;
  end
  assign bus.mem_read_data = ram_q;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] shadow [int];
  logic        m_rl, m_wl;
  int          vectors    = 0;
  int          miscompares = 0;

  function automatic logic [1:0] arb(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive, check combinational outputs, push the
  // expected return, advance a clock, pop and check the registered return.
  task automatic tick(input logic [1:0] rr, input logic [15:0] ra0, input logic [15:0] ra1,
                      input logic [1:0] wr, input logic [15:0] wa0, input logic [15:0] wa1,
                      input logic [15:0] wd0, input logic [15:0] wd1);
    logic [1:0]  gr, gw;
    logic [15:0] ra, wa, wd;
    logic        rinr, winr;
    exp_t        e;
    bus.rd_req = rr; bus.rd_addr0 = ra0; bus.rd_addr1 = ra1;
    bus.wr_req = wr; bus.wr_addr0 = wa0; bus.wr_addr1 = wa1;
    bus.wr_data0 = wd0; bus.wr_data1 = wd1;
    #1;
    gr = arb(rr, m_rl);
    gw = arb(wr, m_wl);
    ra = gr[1] ? ra1 : ra0;
    wa = gw[1] ? wa1 : wa0;
    wd = gw[1] ? wd1 : wd0;
    rinr = ra < 16'h1000;
    winr = wa < 16'h1000;
    chk("rd_gnt", bus.rd_gnt, gr);
    chk("wr_gnt", bus.wr_gnt, gw);
    chk("mem_read_enable", bus.mem_read_enable, (|gr) && rinr);
    chk("mem_write_enable", bus.mem_write_enable, (|gw) && winr);
    if ((|gr) && rinr) chk("mem_read_address", bus.mem_read_address, ra);
    if ((|gw) && winr) begin
      chk("mem_write_address", bus.mem_write_address, wa);
      chk("mem_write_data", bus.mem_write_data, wd);
    end
    e.valid = gr;
    e.err   = (gr & {2{!rinr}}) | (gw & {2{!winr}});
    e.data  = 16'h0000;
    if ((|gr) && rinr) begin
      e.data = shadow.exists(int'(ra)) ? shadow[int'(ra)] : 16'hxxxx;
`ifdef MEM_ARB_WRITE_FORWARD_EN
      if ((|gw) && winr && wa == ra) e.data = wd;
`endif
    end
    sb.push_back(e);
    if ((|gw) && winr) shadow[int'(wa)] = wd;
    if (|gr) m_rl = gr[1];
    if (|gw) m_wl = gw[1];
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rd_valid", bus.rd_valid, e.valid);
    chk("rd_data", bus.rd_data, e.data);
    chk("range_err", bus.range_err, e.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.rd_req = '0; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    bus.wr_req = '0; bus.wr_addr0 = '0; bus.wr_addr1 = '0;
    bus.wr_data0 = '0; bus.wr_data1 = '0;
    m_rl = 1'b1; m_wl = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Requests during reset must not be granted nor reach the RAM.
    bus.rd_req = 2'b11; bus.wr_req = 2'b11;
    #1;
    chk("reset rd_gnt", bus.rd_gnt, 2'b00);
    chk("reset wr_gnt", bus.wr_gnt, 2'b00);
    chk("reset mem_read_enable", bus.mem_read_enable, 1'b0);
    chk("reset mem_write_enable", bus.mem_write_enable, 1'b0);
    chk("reset rd_valid", bus.rd_valid, 2'b00);
    chk("reset rd_data", bus.rd_data, 16'h0000);
    chk("reset range_err", bus.range_err, 2'b00);
    bus.rd_req = '0; bus.wr_req = '0;
    reset = 1'b0;

    // Idle, then write contention: requester 0 wins the first one.
    tick(2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    tick(2'b00, 0, 0, 2'b11, 16'h0010, 16'h0030, 16'hBEEF, 16'h1234);
    tick(2'b00, 0, 0, 2'b10, 16'h0000, 16'h0030, 16'h0000, 16'h1234);
    tick(2'b00, 0, 0, 2'b10, 16'h0000, 16'h0020, 16'h0000, 16'h1111);
    // Read contention for 4 cycles (01,10,01,10); a CPU write runs alongside.
    tick(2'b11, 16'h0010, 16'h0030, 2'b00, 0, 0, 0, 0);
    tick(2'b11, 16'h0010, 16'h0030, 2'b01, 16'h0050, 0, 16'h5050, 0);
    tick(2'b11, 16'h0010, 16'h0030, 2'b00, 0, 0, 0, 0);
    tick(2'b11, 16'h0010, 16'h0030, 2'b00, 0, 0, 0, 0);
    // Single CPU read, then read back the concurrent write.
    tick(2'b01, 16'h0010, 0, 2'b00, 0, 0, 0, 0);
    tick(2'b10, 0, 16'h0050, 2'b00, 0, 0, 0, 0);
    // Same-address read (CPU) and write (DMA), then follow-up read.
    tick(2'b01, 16'h0020, 0, 2'b10, 0, 16'h0020, 0, 16'h2222);
    tick(2'b01, 16'h0020, 0, 2'b00, 0, 0, 0, 0);
    // Out of range write then read by DMA.
    tick(2'b00, 0, 0, 2'b10, 0, 16'h1000, 0, 16'hAAAA);
    tick(2'b10, 0, 16'h1000, 2'b00, 0, 0, 0, 0);
    tick(2'b10, 0, 16'hFFFF, 2'b01, 16'h0FFF, 0, 16'h0F0F, 0);
    tick(2'b00, 0, 0, 2'b00, 0, 0, 0, 0);

    // Reset in the cycle after a read grant; a write during reset is dropped.
    bus.rd_req = 2'b01; bus.rd_addr0 = 16'h0010; bus.wr_req = 2'b00;
    #1;
    chk("pre-reset rd_gnt", bus.rd_gnt, 2'b01);
    @(posedge clk);
    reset = 1'b1;
    bus.rd_req = 2'b00;
    bus.wr_req = 2'b10; bus.wr_addr1 = 16'h0020; bus.wr_data1 = 16'h5555;
    #1;
    chk("mid-reset rd_valid", bus.rd_valid, 2'b00);
    chk("mid-reset rd_data", bus.rd_data, 16'h0000);
    chk("mid-reset wr_gnt", bus.wr_gnt, 2'b00);
    chk("mid-reset mem_write_enable", bus.mem_write_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.wr_req = 2'b00;
    reset = 1'b0;
    m_rl = 1'b1; m_wl = 1'b1;
    sb.delete();
    tick(2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    tick(2'b01, 16'h0020, 0, 2'b00, 0, 0, 0, 0);
    tick(2'b11, 16'h0010, 16'h0030, 2'b00, 0, 0, 0, 0);
    tick(2'b11, 16'h0010, 16'h0030, 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
